// File: rtl/vid_pkg.sv
// -----------------------------------------------------------------------------
// vid_pkg
// Shared video-pipeline definitions used by the centroid stage, the centroid
// marker overlay and any later overlay stages.
//   X_W / Y_W   : widths of the column / row position counters
//   PIX_W       : width of an RGB888 pixel
//   DIFF_W      : width of the signed position differences used by overlays
//   vid_timing_t: bundled de/hsync/vsync timing record
//   abs_diff    : magnitude of a signed position difference
// -----------------------------------------------------------------------------
package vid_pkg;

  localparam int X_W    = 11;
  localparam int Y_W    = 10;
  localparam int PIX_W  = 24;
  localparam int DIFF_W = 12;

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } vid_timing_t;

  // The most negative difference (-2048) maps to 2048, which still fits
  // because the result is treated as unsigned.
  function automatic logic [DIFF_W-1:0] abs_diff(input logic signed [DIFF_W-1:0] d);
    return d[DIFF_W-1] ? DIFF_W'(-d) : DIFF_W'(d);
  endfunction

endpackage

// File: rtl/pixel_pos_counter.sv
// -----------------------------------------------------------------------------
// pixel_pos_counter
// Tracks the column/row of the pixel currently presented on the input stream.
// The registered x/y equal the position of the pixel arriving this cycle.
// Ports:
//   clk, rst (async, active-low), ce (clock enable)
//   de     : data enable of the incoming pixel
//   vsync  : holds the counters at the origin while high
//   x, y   : current pixel position
// -----------------------------------------------------------------------------
module pixel_pos_counter
  import vid_pkg::*;
#(
  parameter int IMG_W = 1280,
  parameter int IMG_H = 720
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           de,
  input  logic           vsync,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y
);

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

  // Counters rest at the origin during vsync, then step once per active pixel,
  // wrapping at the end of each line and at the end of the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x <= '0;
      y <= '0;
    end else if (ce) begin
      if (vsync) begin
        x <= '0;
        y <= '0;
      end else if (de) begin
        if (x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? '0 : y + Y_W'(1);
        end else begin
          x <= x + X_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/centroid_marker.sv
// -----------------------------------------------------------------------------
// centroid_marker
// Overlays a fixed-colour crosshair centred on the tracker's centroid onto the
// pass-through video stream. All outputs are registered: one ce-qualified
// cycle of latency with timing and pixel kept aligned.
// Ports:
//   clk, rst (async, active-low), ce (clock enable for all state)
//   en                       : overlay enable (0 = delayed pass-through)
//   de_i, hsync_i, vsync_i   : input timing
//   pix_i                    : input RGB pixel
//   xcent, ycent             : centroid from the centroid stage
//   de_o, hsync_o, vsync_o   : delayed timing
//   pix_o                    : delayed pixel with crosshair, 0 outside de
// -----------------------------------------------------------------------------
module centroid_marker
  import vid_pkg::*;
#(
  parameter int               IMG_W      = 1280,
  parameter int               IMG_H      = 720,
  parameter int               ARM_LEN    = 16,
  parameter logic [PIX_W-1:0] MARK_COLOR = 24'hFF0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             en,
  input  logic             de_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic [PIX_W-1:0] pix_i,
  input  logic [X_W-1:0]   xcent,
  input  logic [Y_W-1:0]   ycent,
  output logic             de_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic [PIX_W-1:0] pix_o
);

  localparam logic [1:0]        FRAMES_ARMED = 2'd2;
  localparam logic [DIFF_W-1:0] ARM_LIM      = DIFF_W'(ARM_LEN);

  logic [X_W-1:0]          x;
  logic [Y_W-1:0]          y;
  logic                    vsync_q;
  logic [X_W-1:0]          xc;
  logic [Y_W-1:0]          yc;
  logic [1:0]              frames;
  vid_timing_t             tim_q;

  logic                    vsync_fall;
  logic [X_W-1:0]          xc_cur;
  logic [Y_W-1:0]          yc_cur;
  logic [1:0]              frames_next;
  logic                    armed;
  logic signed [DIFF_W-1:0] dx;
  logic signed [DIFF_W-1:0] dy;
  logic [DIFF_W-1:0]       adx;
  logic [DIFF_W-1:0]       ady;
  logic                    hit;
  logic [PIX_W-1:0]        pix_next;

  pixel_pos_counter #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_pos (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .de   (de_i),
    .vsync(vsync_i),
    .x    (x),
    .y    (y)
  );

  // On the vsync falling-edge cycle the freshly captured centroid and the
  // incremented frame count are forwarded, so a pixel arriving in that very
  // cycle already sees the new frame's values.
  always_comb begin
    vsync_fall  = vsync_q & ~vsync_i;
    xc_cur      = vsync_fall ? xcent : xc;
    yc_cur      = vsync_fall ? ycent : yc;
    frames_next = frames;
    if (vsync_fall && (frames != FRAMES_ARMED)) begin
      frames_next = frames + 2'd1;
    end
    armed = (frames_next == FRAMES_ARMED);

    // Absolute positions are compared, so arms are clipped at the image edge
    // instead of wrapping around.
    dx  = $signed({1'b0, x}) - $signed({1'b0, xc_cur});
    dy  = $signed({2'b00, y}) - $signed({2'b00, yc_cur});
    adx = abs_diff(dx);
    ady = abs_diff(dy);
    hit = ((dx == '0) && (ady <= ARM_LIM)) || ((dy == '0) && (adx <= ARM_LIM));

    pix_next = '0;
    if (de_i) begin
      pix_next = (en && armed && hit) ? MARK_COLOR : pix_i;
    end
  end

  // Centroid is held for the whole frame to avoid tearing; the frame counter
  // saturates once armed so the marker stays on until the next reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q <= 1'b0;
      xc      <= '0;
      yc      <= '0;
      frames  <= '0;
      tim_q   <= '0;
      pix_o   <= '0;
    end else if (ce) begin
      vsync_q <= vsync_i;
      if (vsync_fall) begin
        xc <= xcent;
        yc <= ycent;
      end
      frames <= frames_next;
      tim_q  <= '{de: de_i, hsync: hsync_i, vsync: vsync_i};
      pix_o  <= pix_next;
    end
  end

  assign de_o    = tim_q.de;
  assign hsync_o = tim_q.hsync;
  assign vsync_o = tim_q.vsync;

endmodule

// File: tb/tb_centroid_marker.sv
// -----------------------------------------------------------------------------
// tb_centroid_marker
// Self-checking bench for centroid_marker on a small 16x8 image with 2-pixel
// arms. A reference model tracks position, latched centroid and arming from
// the behavioural rules and predicts every output cycle; per-frame marker
// counts are additionally pinned against hand-computed values.
// -----------------------------------------------------------------------------
module tb_centroid_marker;

  localparam int          IMG_W   = 16;
  localparam int          IMG_H   = 8;
  localparam int          ARM_LEN = 2;
  localparam logic [23:0] MARK    = 24'hFF0000;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        en;
  logic        de_i;
  logic        hsync_i;
  logic        vsync_i;
  logic [23:0] pix_i;
  logic [10:0] xcent;
  logic [9:0]  ycent;
  logic        de_o;
  logic        hsync_o;
  logic        vsync_o;
  logic [23:0] pix_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit ce_toggle = 0;

  // Output-side marker bookkeeping
  int ox = 0, oy = 0;
  int mk_total = 0, mk_edge = 0, mk_col8 = 0, mk_col3 = 0;

  centroid_marker #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .ARM_LEN   (ARM_LEN),
    .MARK_COLOR(MARK)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .en     (en),
    .de_i   (de_i),
    .hsync_i(hsync_i),
    .vsync_i(vsync_i),
    .pix_i  (pix_i),
    .xcent  (xcent),
    .ycent  (ycent),
    .de_o   (de_o),
    .hsync_o(hsync_o),
    .vsync_o(vsync_o),
    .pix_o  (pix_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_x, m_y, m_xc, m_yc, m_falls;
  logic        m_pvs, m_upd;
  logic        e_de, e_hs, e_vs;
  logic [23:0] e_pix;
  logic        m_fall;

  assign m_fall = m_pvs & ~vsync_i;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [23:0] model_pixel(input int x, input int y, input int xc,
                                              input int yc, input bit armed, input logic de,
                                              input logic ov_en, input logic [23:0] px);
    bit on_cross;
    on_cross = ((x == xc) && (iabs(y - yc) <= ARM_LEN)) ||
               ((y == yc) && (iabs(x - xc) <= ARM_LEN));
    if (!de) return 24'h0;
    if (ov_en && armed && on_cross) return MARK;
    return px;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_x <= 0; m_y <= 0; m_xc <= 0; m_yc <= 0; m_falls <= 0;
      m_pvs <= 1'b0; m_upd <= 1'b0;
      e_de <= 1'b0; e_hs <= 1'b0; e_vs <= 1'b0; e_pix <= '0;
    end else begin
      m_upd <= ce;
      if (ce) begin
        m_pvs <= vsync_i;
        if (m_fall) begin
          m_xc    <= int'(xcent);
          m_yc    <= int'(ycent);
          m_falls <= m_falls + 1;
        end
        e_de  <= de_i;
        e_hs  <= hsync_i;
        e_vs  <= vsync_i;
        e_pix <= model_pixel(m_x, m_y,
                             m_fall ? int'(xcent) : m_xc,
                             m_fall ? int'(ycent) : m_yc,
                             (m_falls + (m_fall ? 1 : 0)) >= 2,
                             de_i, en, pix_i);
        if (vsync_i) begin
          m_x <= 0; m_y <= 0;
        end else if (de_i) begin
          if (m_x == IMG_W - 1) begin
            m_x <= 0;
            m_y <= (m_y == IMG_H - 1) ? 0 : m_y + 1;
          end else begin
            m_x <= m_x + 1;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic checkLiteral(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput();
    n_cmp++;
    if ({de_o, hsync_o, vsync_o, pix_o} !== {e_de, e_hs, e_vs, e_pix}) begin
      n_bad++;
      $display("[TB] FAIL out_cycle t=%0t: got de=%b hs=%b vs=%b pix=%h, expected de=%b hs=%b vs=%b pix=%h",
               $time, de_o, hsync_o, vsync_o, pix_o, e_de, e_hs, e_vs, e_pix);
    end
    if (!rst) begin
      ox = 0; oy = 0;
    end else if (m_upd) begin
      if (vsync_o) begin
        ox = 0; oy = 0;
      end else if (de_o) begin
        if (pix_o == MARK) begin
          mk_total++;
          if (ox >= IMG_W - 2 || oy >= IMG_H - 2) mk_edge++;
          if (ox == 8) mk_col8++;
          if (ox == 3) mk_col3++;
        end
        ox++;
        if (ox == IMG_W) begin
          ox = 0; oy++;
          if (oy == IMG_H) oy = 0;
        end
      end
    end
  endtask

  // Inputs change at the falling edge; outputs are checked one falling edge
  // later. With ce toggling each sample is held for an enabled and a
  // disabled clock.
  task automatic applyStimulus(input logic de, input logic hs, input logic vs,
                               input logic [23:0] px);
    de_i = de; hsync_i = hs; vsync_i = vs; pix_i = px; ce = 1'b1;
    @(posedge clk); @(negedge clk); checkOutput();
    if (ce_toggle) begin
      ce = 1'b0;
      @(posedge clk); @(negedge clk); checkOutput();
    end
  endtask

  function automatic logic [23:0] rand_pix();
    return {8'($urandom_range(0, 254)), 16'($urandom)};
  endfunction

  task automatic run_frame(input int xc, input int yc, input bit with_vs,
                           input int chg_line, input int new_x, input int rst_line,
                           output int tot, output int edg, output int c8, output int c3);
    int b_t, b_e, b_8, b_3;
    b_t = mk_total; b_e = mk_edge; b_8 = mk_col8; b_3 = mk_col3;
    xcent = 11'(xc);
    ycent = 10'(yc);
    if (with_vs) for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 24'h0);
    for (int ln = 0; ln < IMG_H; ln++) begin
      if (ln == chg_line) xcent = 11'(new_x);
      if (ln == rst_line) begin
        rst = 1'b0;
        #1;
        checkLiteral("rst_async_out", int'({de_o, hsync_o, vsync_o, pix_o}), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
        rst = 1'b1;
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 24'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 24'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
      for (int p = 0; p < IMG_W; p++) applyStimulus(1'b1, 1'b0, 1'b0, rand_pix());
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    tot = mk_total - b_t;
    edg = mk_edge - b_e;
    c8  = mk_col8 - b_8;
    c3  = mk_col3 - b_3;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t, e, c8, c3;
    rst = 1'b0; ce = 1'b1; en = 1'b1;
    de_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0; pix_i = '0;
    xcent = '0; ycent = '0;
    #3;
    checkLiteral("reset_out", int'({de_o, hsync_o, vsync_o, pix_o}), 0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] arming after reset, centroid (8,4)");
    run_frame(8, 4, 1'b0, -1, 0, -1, t, e, c8, c3);
    checkLiteral("frame1_marks", t, 0);
    run_frame(8, 4, 1'b1, -1, 0, -1, t, e, c8, c3);
    checkLiteral("frame2_marks", t, 0);
    run_frame(8, 4, 1'b1, -1, 0, -1, t, e, c8, c3);
    checkLiteral("frame3_marks", t, 9);
    checkLiteral("frame3_col8", c8, 5);

    $display("[TB] corner centroid (0,0)");
    run_frame(0, 0, 1'b1, -1, 0, -1, t, e, c8, c3);
    checkLiteral("corner_marks", t, 5);
    checkLiteral("corner_no_wrap", e, 0);

    $display("[TB] centroid changed mid-frame");
    run_frame(8, 4, 1'b1, 3, 3, -1, t, e, c8, c3);
    checkLiteral("midchg_col8", c8, 5);
    checkLiteral("midchg_col3", c3, 0);
    run_frame(3, 4, 1'b1, -1, 0, -1, t, e, c8, c3);
    checkLiteral("next_col3", c3, 5);
    checkLiteral("next_col8", c8, 0);
    checkLiteral("next_marks", t, 9);

    $display("[TB] overlay disabled");
    en = 1'b0;
    run_frame(8, 4, 1'b1, -1, 0, -1, t, e, c8, c3);
    checkLiteral("en0_marks", t, 0);
    en = 1'b1;

    $display("[TB] ce toggling");
    ce_toggle = 1'b1;
    run_frame(8, 4, 1'b1, -1, 0, -1, t, e, c8, c3);
    checkLiteral("ce_marks", t, 9);
    checkLiteral("ce_col8", c8, 5);
    ce_toggle = 1'b0;

    $display("[TB] reset mid-frame");
    run_frame(8, 4, 1'b1, -1, 0, 3, t, e, c8, c3);
    run_frame(8, 4, 1'b1, -1, 0, -1, t, e, c8, c3);
    checkLiteral("post_rst_f1_marks", t, 0);
    run_frame(8, 4, 1'b1, -1, 0, -1, t, e, c8, c3);
    checkLiteral("post_rst_f2_marks", t, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
